// File: rtl/sum_until_zero_if.sv
// ----------------------------------------------------------------------------
// sum_until_zero_if
//   Bundles the stimulus and result signals of the sum_until_zero accumulator.
//   The clock and reset are not part of the bundle; they stay plain ports on
//   the accumulator.
//
//   Signals
//     go_l       active-low start strobe, driven by the stimulus side
//     inA        value stream, one value per clock, driven by the stimulus side
//     outResult  running / final sum, driven by the accumulator
//     done       high while the accumulator holds a finished result
//     overflow   sticky carry out of the MSB during the current run
//     timeout    run ended on the value limit rather than on a zero value
//     count      number of values summed in the current run (zero included)
//
//   Modports
//     master     stimulus / checker side
//     slave      accumulator side
// ----------------------------------------------------------------------------
interface sum_until_zero_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 9
);
    logic             go_l;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] outResult;
    logic             done;
    logic             overflow;
    logic             timeout;
    logic [CNT_W-1:0] count;

    // The stimulus generator drives the strobe and the data stream and
    // observes every result field.
    modport master (
        output go_l,
        output inA,
        input  outResult,
        input  done,
        input  overflow,
        input  timeout,
        input  count
    );

    // The accumulator consumes the strobe and data stream and owns every
    // result field.
    modport slave (
        input  go_l,
        input  inA,
        output outResult,
        output done,
        output overflow,
        output timeout,
        output count
    );
endinterface

// File: rtl/sum_until_zero.sv
// ----------------------------------------------------------------------------
// sum_until_zero
//   Accumulator stage. A low go_l seen at a clock edge starts a run: the value
//   on inA at that edge and every following edge is added to a WIDTH-bit
//   wrapping sum. The run ends when a zero value arrives or when MAX_COUNT
//   values have been taken. The result is then held with done high until the
//   next start strobe.
//
//   Parameters
//     WIDTH      data width of inA / outResult; the sum wraps mod 2**WIDTH
//     CNT_W      width of the count output
//     MAX_COUNT  values accumulated before a forced finish (>=1, <2**CNT_W)
//
//   Ports
//     ck         clock; all state updates on its rising edge
//     reset      asynchronous, active-high reset; aborts any run in progress
//     bus        sum_until_zero_if slave modport:
//                  go_l, inA                        (in)
//                  outResult, done, overflow,
//                  timeout, count                   (out, all registered)
// ----------------------------------------------------------------------------
module sum_until_zero #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 9,
    parameter int MAX_COUNT = 511
) (
    input  logic                  ck,
    input  logic                  reset,
    sum_until_zero_if.slave       bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_COUNT);
    // With a limit of one the very first value already exhausts the run.
    localparam bit               LIMIT_ONE = (MAX_COUNT == 1);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] sum_q,      sum_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             overflow_q, overflow_d;
    logic             timeout_q,  timeout_d;
    logic             done_q,     done_d;

    logic [WIDTH:0]   sum_ext;
    logic [CNT_W-1:0] count_inc;
    logic             in_zero;

    // Next-state and next-output computation. Everything holds by default, so
    // the DONE state freezes the result simply by not touching it. A start
    // from IDLE and a restart from DONE are the same operation: the first
    // value is loaded rather than added, and the flags are cleared.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;

        sum_ext   = {1'b0, sum_q} + {1'b0, bus.inA};
        count_inc = count_q + CNT_ONE;
        in_zero   = (bus.inA == '0);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (!bus.go_l) begin
                    sum_d      = bus.inA;
                    count_d    = CNT_ONE;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b0;
                    if (in_zero) begin
                        state_d = S_DONE;
                    end else if (LIMIT_ONE) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                // A zero adds nothing but is still counted. When the zero and
                // the limit coincide the zero wins and no timeout is flagged.
                sum_d      = sum_ext[WIDTH-1:0];
                count_d    = count_inc;
                overflow_d = overflow_q | sum_ext[WIDTH];
                if (in_zero) begin
                    state_d = S_DONE;
                end else if (count_inc == CNT_LIMIT) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // done is registered from the next state so it rises the cycle after
        // the terminating value was sampled.
        done_d = (state_d == S_DONE);
    end

    // State and output registers. Reset takes effect immediately so a run in
    // progress is discarded without leaving a partial result behind.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sum_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
        end
    end

    assign bus.outResult = sum_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.timeout   = timeout_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sum_until_zero.sv
// ----------------------------------------------------------------------------
// tb_sum_until_zero
//   Drives two accumulators with identical stimulus: one with the default
//   value limit (511) and one with a limit of 4. Expected results come from a
//   reference model that walks the value list directly with integer sums.
// ----------------------------------------------------------------------------
module tb_sum_until_zero;

    localparam int WIDTH = 8;
    localparam int CNT_W = 9;
    localparam int MAX_A = 511;
    localparam int MAX_B = 4;

    logic ck = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    logic             go_l_drv [2];
    logic [WIDTH-1:0] in_drv;

    sum_until_zero_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_a ();
    sum_until_zero_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_b ();

    sum_until_zero #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_COUNT(MAX_A)) dut_a (
        .ck    (ck),
        .reset (reset),
        .bus   (bus_a)
    );

    sum_until_zero #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_COUNT(MAX_B)) dut_b (
        .ck    (ck),
        .reset (reset),
        .bus   (bus_b)
    );

    assign bus_a.go_l = go_l_drv[0];
    assign bus_b.go_l = go_l_drv[1];
    assign bus_a.inA  = in_drv;
    assign bus_b.inA  = in_drv;

    logic             obs_done [2];
    logic [WIDTH-1:0] obs_res  [2];
    logic [CNT_W-1:0] obs_cnt  [2];
    logic             obs_ovf  [2];
    logic             obs_to   [2];

    assign obs_done[0] = bus_a.done;
    assign obs_res[0]  = bus_a.outResult;
    assign obs_cnt[0]  = bus_a.count;
    assign obs_ovf[0]  = bus_a.overflow;
    assign obs_to[0]   = bus_a.timeout;
    assign obs_done[1] = bus_b.done;
    assign obs_res[1]  = bus_b.outResult;
    assign obs_cnt[1]  = bus_b.count;
    assign obs_ovf[1]  = bus_b.overflow;
    assign obs_to[1]   = bus_b.timeout;

    always #5 ck = ~ck;

    function automatic int max_of(input int d);
        return (d == 0) ? MAX_A : MAX_B;
    endfunction

    // Packs the observed outputs as {done, outResult, count, overflow, timeout}.
    function automatic logic [19:0] snap(input int d);
        return {obs_done[d], obs_res[d], obs_cnt[d], obs_ovf[d], obs_to[d]};
    endfunction

    function automatic logic [19:0] pack_exp(input bit dn, input int s, input int c,
                                             input bit o, input bit t);
        return {dn, 8'(s), 9'(c), o, t};
    endfunction

    // Reference model: take values in order (zero once the list runs out)
    // until a zero is taken or the limit is reached. The carry flag is set
    // whenever the true, unwrapped total reaches 2**WIDTH.
    function automatic void model(input logic [7:0] vals[$], input int maxc,
                                  output int sum, output int cnt,
                                  output bit ovf, output bit tmo);
        int total;
        int v;
        total = 0;
        cnt   = 0;
        tmo   = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            v = (k < vals.size()) ? int'(vals[k]) : 0;
            total += v;
            cnt = k + 1;
            if (v == 0) break;
            if (cnt == maxc) tmo = 1'b1;
        end
        sum = total % 256;
        ovf = (total >= 256);
    endfunction

    // Starts a run on both accumulators and feeds values until both are
    // expected to have finished. Records, per accumulator, the index of the
    // edge after which done was first seen high. With noisy set, go_l is
    // toggled at random while an accumulator is mid-run.
    task automatic drive_run(input logic [7:0] vals[$], input int n0, input int n1,
                             input bit noisy, output int rise0, output int rise1);
        int last;
        last  = ((n0 > n1) ? n0 : n1) - 1;
        rise0 = -1;
        rise1 = -1;
        for (int i = 0; i <= last; i++) begin
            in_drv = (i < vals.size()) ? vals[i] : 8'd0;
            go_l_drv[0] = (i == 0) ? 1'b0 : ((noisy && i < n0) ? 1'($urandom % 2) : 1'b1);
            go_l_drv[1] = (i == 0) ? 1'b0 : ((noisy && i < n1) ? 1'($urandom % 2) : 1'b1);
            @(posedge ck);
            #1;
            if (rise0 < 0 && obs_done[0] === 1'b1) rise0 = i;
            if (rise1 < 0 && obs_done[1] === 1'b1) rise1 = i;
        end
        go_l_drv[0] = 1'b1;
        go_l_drv[1] = 1'b1;
        in_drv      = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            go_l_drv[0] = 1'(i % 2);
            go_l_drv[1] = 1'(i % 2);
            in_drv      = 8'($urandom_range(1, 255));
            @(posedge ck);
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (snap(d) !== 20'd0) begin
                    miscompares++;
                    $display("[TB] FAIL reset_hold dut%0d cycle %0d: got %h, expected 00000", d, i, snap(d));
                end
            end
        end
        go_l_drv[0] = 1'b1;
        go_l_drv[1] = 1'b1;
        #2 reset = 1'b0;
        @(posedge ck);
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (snap(d) !== 20'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_release dut%0d: got %h, expected 00000", d, snap(d));
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] v[$];
        int s[2], c[2], r[2];
        bit o[2], t[2];
        v = '{8'd3, 8'd5, 8'd7, 8'd0};
        for (int d = 0; d < 2; d++) model(v, max_of(d), s[d], c[d], o[d], t[d]);
        drive_run(v, c[0], c[1], 1'b0, r[0], r[1]);
        for (int d = 0; d < 2; d++) begin
            vectors += 2;
            if (r[d] !== c[d] - 1) begin miscompares++; $display("[TB] FAIL basic_latency dut%0d: got %0d, expected %0d", d, r[d], c[d] - 1); end
            if (snap(d) !== pack_exp(1'b1, s[d], c[d], o[d], t[d])) begin miscompares++; $display("[TB] FAIL basic_result dut%0d: got %h, expected %h", d, snap(d), pack_exp(1'b1, s[d], c[d], o[d], t[d])); end
        end
        for (int k = 0; k < 20; k++) begin
            in_drv = 8'($urandom);
            @(posedge ck);
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (snap(d) !== pack_exp(1'b1, s[d], c[d], o[d], t[d])) begin miscompares++; $display("[TB] FAIL basic_hold dut%0d cycle %0d: got %h, expected %h", d, k, snap(d), pack_exp(1'b1, s[d], c[d], o[d], t[d])); end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] v[$];
        int s[2], c[2], r[2];
        bit o[2], t[2];
        v = '{8'd200, 8'd100, 8'd0};
        for (int d = 0; d < 2; d++) model(v, max_of(d), s[d], c[d], o[d], t[d]);
        drive_run(v, c[0], c[1], 1'b0, r[0], r[1]);
        for (int d = 0; d < 2; d++) begin
            vectors += 2;
            if (r[d] !== c[d] - 1) begin miscompares++; $display("[TB] FAIL overflow_latency dut%0d: got %0d, expected %0d", d, r[d], c[d] - 1); end
            if (snap(d) !== pack_exp(1'b1, s[d], c[d], o[d], t[d])) begin miscompares++; $display("[TB] FAIL overflow_result dut%0d: got %h, expected %h", d, snap(d), pack_exp(1'b1, s[d], c[d], o[d], t[d])); end
        end
    endtask

    task automatic test_max_count();
        logic [7:0] v[$];
        int s[2], c[2], r[2];
        bit o[2], t[2];
        for (int sc = 0; sc < 3; sc++) begin
            v.delete();
            if (sc == 0) v = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
            else if (sc == 1) v = '{8'd1, 8'd1, 8'd1, 8'd0};
            else for (int k = 0; k < 520; k++) v.push_back(8'($urandom_range(1, 255)));
            for (int d = 0; d < 2; d++) model(v, max_of(d), s[d], c[d], o[d], t[d]);
            drive_run(v, c[0], c[1], 1'b0, r[0], r[1]);
            for (int d = 0; d < 2; d++) begin
                vectors += 2;
                if (r[d] !== c[d] - 1) begin miscompares++; $display("[TB] FAIL max_latency sc%0d dut%0d: got %0d, expected %0d", sc, d, r[d], c[d] - 1); end
                if (snap(d) !== pack_exp(1'b1, s[d], c[d], o[d], t[d])) begin miscompares++; $display("[TB] FAIL max_result sc%0d dut%0d: got %h, expected %h", sc, d, snap(d), pack_exp(1'b1, s[d], c[d], o[d], t[d])); end
            end
        end
    endtask

    task automatic test_zero_restart();
        logic [7:0] v[$];
        int s[2], c[2], r[2];
        bit o[2], t[2];
        for (int sc = 0; sc < 2; sc++) begin
            if (sc == 0) v = '{8'd0};
            else v = '{8'd9, 8'd0};
            for (int d = 0; d < 2; d++) model(v, max_of(d), s[d], c[d], o[d], t[d]);
            drive_run(v, c[0], c[1], 1'b0, r[0], r[1]);
            for (int d = 0; d < 2; d++) begin
                vectors += 2;
                if (r[d] !== c[d] - 1) begin miscompares++; $display("[TB] FAIL restart_latency sc%0d dut%0d: got %0d, expected %0d", sc, d, r[d], c[d] - 1); end
                if (snap(d) !== pack_exp(1'b1, s[d], c[d], o[d], t[d])) begin miscompares++; $display("[TB] FAIL restart_result sc%0d dut%0d: got %h, expected %h", sc, d, snap(d), pack_exp(1'b1, s[d], c[d], o[d], t[d])); end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] v[$];
        int s[2], c[2], r[2];
        bit o[2], t[2];
        go_l_drv[0] = 1'b0; go_l_drv[1] = 1'b0; in_drv = 8'd10;
        @(posedge ck);
        #1;
        go_l_drv[0] = 1'b1; go_l_drv[1] = 1'b1; in_drv = 8'd20;
        @(posedge ck);
        #1;
        in_drv = 8'd30;
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (snap(d) !== 20'd0) begin miscompares++; $display("[TB] FAIL midrun_async dut%0d: got %h, expected 00000", d, snap(d)); end
        end
        @(posedge ck);
        #1 reset = 1'b0;
        @(posedge ck);
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (snap(d) !== 20'd0) begin miscompares++; $display("[TB] FAIL midrun_idle dut%0d: got %h, expected 00000", d, snap(d)); end
        end
        v = '{8'd4, 8'd0};
        for (int d = 0; d < 2; d++) model(v, max_of(d), s[d], c[d], o[d], t[d]);
        drive_run(v, c[0], c[1], 1'b1, r[0], r[1]);
        for (int d = 0; d < 2; d++) begin
            vectors += 2;
            if (r[d] !== c[d] - 1) begin miscompares++; $display("[TB] FAIL midrun_latency dut%0d: got %0d, expected %0d", d, r[d], c[d] - 1); end
            if (snap(d) !== pack_exp(1'b1, s[d], c[d], o[d], t[d])) begin miscompares++; $display("[TB] FAIL midrun_result dut%0d: got %h, expected %h", d, snap(d), pack_exp(1'b1, s[d], c[d], o[d], t[d])); end
        end
    endtask

    task automatic test_random();
        logic [7:0] v[$];
        int s[2], c[2], r[2];
        bit o[2], t[2];
        int len;
        int idle;
        for (int run = 0; run < 40; run++) begin
            v.delete();
            len = $urandom_range(0, 9);
            for (int k = 0; k < len; k++) v.push_back(8'($urandom_range(1, 255)));
            for (int d = 0; d < 2; d++) model(v, max_of(d), s[d], c[d], o[d], t[d]);
            drive_run(v, c[0], c[1], 1'b1, r[0], r[1]);
            for (int d = 0; d < 2; d++) begin
                vectors += 2;
                if (r[d] !== c[d] - 1) begin miscompares++; $display("[TB] FAIL random_latency run%0d dut%0d: got %0d, expected %0d", run, d, r[d], c[d] - 1); end
                if (snap(d) !== pack_exp(1'b1, s[d], c[d], o[d], t[d])) begin miscompares++; $display("[TB] FAIL random_result run%0d dut%0d: got %h, expected %h", run, d, snap(d), pack_exp(1'b1, s[d], c[d], o[d], t[d])); end
            end
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                in_drv = 8'($urandom);
                @(posedge ck);
                #1;
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if (snap(d) !== pack_exp(1'b1, s[d], c[d], o[d], t[d])) begin miscompares++; $display("[TB] FAIL random_hold run%0d dut%0d: got %h, expected %h", run, d, snap(d), pack_exp(1'b1, s[d], c[d], o[d], t[d])); end
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        go_l_drv[0] = 1'b1;
        go_l_drv[1] = 1'b1;
        in_drv      = 8'd0;
        @(posedge ck);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_max_count();
        test_zero_restart();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached before the test sequence ended");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
